riscv_ras: RTL
==============

// Module: riscv_ras
// PURPOSE
//  Parametrised return-address stack (RAS) for jal/jalr target prediction.
//  Decodes each fetched instruction and applies the RISC-V link-register hints:
//  calls push pc+4, returns pop the stack, and a return-and-call replaces the top.
//  Sits beside the fetch stage of the riscv cores. Predicts return targets one
//  cycle before the jalr resolves in the datapath.
// PARAMETERS
//  DEPTH   8   entries; power of two, >= 2
//  XLEN    32  address width
//  CNT_W   $clog2(DEPTH)+1  width of count (derived localparam, not overridable)
// PORTS
//  clk           in   1      clock
//  rst           in   1      reset; synchronous, active-high
//  instr_valid   in   1      instr/pc are valid this cycle
//  instr         in   32     fetched instruction
//  pc            in   XLEN   pc of instr
//  ckpt_save     in   1      snapshot stack pointer and count
//  ckpt_restore  in   1      restore the snapshot (mispredict flush)
//  pred_valid    out  1      instr is a return and the stack is non-empty
//  pred_target   out  XLEN   top entry (combinational from registers)
//  count         out  CNT_W  live entries, 0..DEPTH
//  empty         out  1      count == 0
//  full          out  1      count == DEPTH
//  overflow      out  1      1-cycle pulse: push while full (oldest entry lost)
//  underflow     out  1      1-cycle pulse: pop while empty
// BEHAVIOUR
//  - Reset: sp=0, count=0, all entries 0, overflow=underflow=0, snapshot cleared.
//    pred_valid=0 while rst is high.
//  - Decode when instr_valid. link = rd or rs1 in {x1,x5}.
//    - jal (opcode 1101111): push if rd is link.
//    - jalr (opcode 1100111):
//      - rd !link, rs1 link -> pop.
//      - rd link, rs1 !link -> push.
//      - rd link, rs1 link, rd != rs1 -> pop+push (replace).
//      - rd link, rs1 link, rd == rs1 -> push.
//    - All other instructions leave the stack unchanged.
//  - Every stack update takes effect on the next posedge clk.
//    pred_target and pred_valid are combinational: pop-type instr -> pred_valid=!empty.
//  - Push: mem[sp]<=pc+XLEN'd4 (wraps mod 2^XLEN); sp<=sp+1 mod DEPTH.
//    count<=min(count+1,DEPTH). If full: oldest entry is overwritten (circular),
//    count stays DEPTH, overflow pulses.
//  - Pop: sp<=sp-1 mod DEPTH; count<=count-1. If empty: no change, underflow pulses.
//  - Replace: mem[sp-1]<=pc+4; sp and count unchanged. If empty: acts as a push.
//  - pred_target = mem[sp-1 mod DEPTH]. Value is don't-care when empty.
//  - instr_valid=0 with no ckpt input active: nothing changes; pulses are 0.
//  - rst has priority over everything. Reset mid-sequence discards all entries.
// CONFIGURATION
//  RAS_CHECKPOINT_EN defined:
//    - ckpt_save latches {sp,count} at the posedge.
//    - ckpt_restore loads {sp,count} from the snapshot. Entry contents are not restored.
//    - restore beats save beats the decode update in the same cycle. The instr is
//      dropped and no pulses are generated.
//  RAS_CHECKPOINT_EN undefined:
//    - ckpt_save and ckpt_restore are ignored; no snapshot registers exist.
// TESTING
//  1. rst=1 for 1 cycle -> count=0, empty=1, full=0, pred_valid=0, pulses 0.
//  2. pc=0x0, 0x008000ef (jal ra,8) -> count=1.
//     Then 0x00008067 (jalr x0,ra,0) -> pred_valid=1, pred_target=0x4;
//     next cycle count=0, empty=1.
//  3. pc=0x10, 0x004180e7 (jalr ra,x3,4) -> push 0x14.
//     Then 0x000080e7 (jalr ra,ra,0, rd==rs1) -> push; count=2, top=pc+4.
//     Then pc=0x30, 0x000280e7 (jalr ra,x5,0) -> replace top with 0x34; count=2.
//  4. DEPTH+1 jal ra at pc=4*k -> overflow pulses on the last push; count=DEPTH.
//     DEPTH pops return 4*DEPTH+4 down to 4*1+4 (entry 0x4 lost).
//     Extra pop -> underflow pulse, count=0.
//  5. Return instr on an empty stack -> pred_valid=0, underflow=1 next cycle.
//     Reset asserted during a push -> count=0.
//  6. (RAS_CHECKPOINT_EN) push A,B; ckpt_save; push C; pop; pop; ckpt_restore
//     -> count=2, pred_target=B.
//     Restore together with a push -> the push is dropped.

Source files
------------

// File: rtl/riscv_ras.sv
// riscv_ras: return-address stack for jal/jalr target prediction.
// Decodes each fetched instruction using the RISC-V link-register hints:
// calls push pc+4, returns pop, and a return-and-call replaces the top.
// The stack is circular, so a push while full silently drops the oldest entry.
//
// Optional feature: define RAS_CHECKPOINT_EN to add a {sp,count} snapshot
// that can be saved and restored (mispredict flush). Without it the ckpt
// inputs are ignored and no snapshot registers exist.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   instr_valid    instr/pc valid this cycle
//   instr, pc      fetched instruction and its address
//   ckpt_save      snapshot sp/count
//   ckpt_restore   restore the snapshot
//   pred_valid     instr is a return and the stack is non-empty
//   pred_target    current top entry
//   count          live entries, 0..DEPTH
//   empty, full    count == 0 / count == DEPTH
//   overflow       1-cycle pulse after a push while full
//   underflow      1-cycle pulse after a pop while empty
module riscv_ras #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned XLEN  = 32,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  pc,
    input  logic             ckpt_save,
    input  logic             ckpt_restore,
    output logic             pred_valid,
    output logic [XLEN-1:0]  pred_target,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned SP_W = $clog2(DEPTH);

    logic [XLEN-1:0]  mem_q [DEPTH];
    logic [SP_W-1:0]  sp_q, sp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             wr_en;
    logic [SP_W-1:0]  wr_idx;
    logic [XLEN-1:0]  link_addr;
    logic [SP_W-1:0]  top_idx;

    // Instruction decode
    logic [6:0] opcode;
    logic [4:0] rd, rs1;
    logic       rd_link, rs1_link, is_jal, is_jalr;
    logic       do_push, do_pop, do_repl;

    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign rs1      = instr[19:15];
    assign rd_link  = (rd == 5'd1) || (rd == 5'd5);
    assign rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);
    assign is_jal   = instr_valid && (opcode == 7'b1101111);
    assign is_jalr  = instr_valid && (opcode == 7'b1100111);

    assign do_push = (is_jal && rd_link)
                   || (is_jalr && rd_link && (!rs1_link || (rd == rs1)));
    assign do_pop  = is_jalr && !rd_link && rs1_link;
    assign do_repl = is_jalr && rd_link && rs1_link && (rd != rs1);

    assign link_addr = pc + XLEN'(4);
    assign top_idx   = sp_q - SP_W'(1);

    // Checkpoint: restore wins over save, and either one drops the decode update.
    logic ckpt_block;
`ifdef RAS_CHECKPOINT_EN
    logic [SP_W-1:0]  snap_sp_q;
    logic [CNT_W-1:0] snap_cnt_q;
    logic             unused_bits;

    assign ckpt_block  = ckpt_save || ckpt_restore;
    assign unused_bits = ^{instr[31:20], instr[14:12]};

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_sp_q  <= '0;
            snap_cnt_q <= '0;
        end else if (ckpt_save && !ckpt_restore) begin
            snap_sp_q  <= sp_q;
            snap_cnt_q <= cnt_q;
        end
    end
`else
    logic unused_bits;

    assign ckpt_block  = 1'b0;
    assign unused_bits = ^{instr[31:20], instr[14:12], ckpt_save, ckpt_restore};
`endif

    // Next-state
    always_comb begin
        sp_d   = sp_q;
        cnt_d  = cnt_q;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        wr_en  = 1'b0;
        wr_idx = sp_q;
`ifdef RAS_CHECKPOINT_EN
        if (ckpt_restore) begin
            sp_d  = snap_sp_q;
            cnt_d = snap_cnt_q;
        end
`endif
        if (!ckpt_block) begin
            // Replace on an empty stack degenerates to a push.
            if (do_push || (do_repl && empty)) begin
                wr_en = 1'b1;
                sp_d  = sp_q + SP_W'(1);
                if (full) ovf_d = 1'b1;
                else      cnt_d = cnt_q + CNT_W'(1);
            end else if (do_repl) begin
                wr_en  = 1'b1;
                wr_idx = top_idx;
            end else if (do_pop) begin
                if (empty) begin
                    unf_d = 1'b1;
                end else begin
                    sp_d  = top_idx;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            if (wr_en) mem_q[wr_idx] <= link_addr;
        end
    end

    // Outputs
    assign count       = cnt_q;
    assign empty       = (cnt_q == '0);
    assign full        = (cnt_q == CNT_W'(DEPTH));
    assign overflow    = ovf_q;
    assign underflow   = unf_q;
    assign pred_target = mem_q[top_idx];
    assign pred_valid  = !rst && (do_pop || do_repl) && !empty;

endmodule
